// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared CPU defaults and instruction field helper
package regfile_sb_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_INST_W   = 16;
  localparam int DEF_RD_LSB   = 9;
  localparam int DEF_RS1_LSB  = 6;
  localparam int DEF_RS2_LSB  = 3;

  // Widest instruction word the field helper accepts.
  localparam int MAX_INST_W   = 64;

  // Pull an aw-bit register index out of an instruction word starting at lsb.
  function automatic logic [31:0] get_field(input logic [MAX_INST_W-1:0] inst,
                                            input int unsigned lsb,
                                            input int unsigned aw);
    logic [MAX_INST_W-1:0] mask;
    mask = (MAX_INST_W'(1) << aw) - MAX_INST_W'(1);
    return 32'((inst >> lsb) & mask);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - decode-side bus between instruction decode and the register file
interface regfile_sb_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int INST_W   = 16
);
  localparam int AW = $clog2(NUM_REGS);

  logic [INST_W-1:0]   inst;
  logic                issue_en;
  logic                issue_wb;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   reg_data1;
  logic [DATA_W-1:0]   reg_data2;
  logic                stall;
  logic [NUM_REGS-1:0] pending;

  modport master (
    output inst, issue_en, issue_wb, wr_en, wr_addr, wr_data,
    input  reg_data1, reg_data2, stall, pending
  );

  modport slave (
    input  inst, issue_en, issue_wb, wr_en, wr_addr, wr_data,
    output reg_data1, reg_data2, stall, pending
  );
endinterface

// File: rtl/regfile_sb_score.sv
// rtl/regfile_sb_score.sv - pending-writeback scoreboard and decode stall generation
module regfile_sb_score #(
  parameter int NUM_REGS = 8,
  parameter int AW       = 3,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       rs1,
  input  logic [AW-1:0]       rs2,
  input  logic [AW-1:0]       rd,
  input  logic                issue_en,
  input  logic                issue_wb,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending
);

  logic                hit1;
  logic                hit2;
  logic                waw;
  logic                issue;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // Hazard detection; a writeback landing this cycle resolves RAW only when it can be forwarded.
  always_comb begin
    hit1 = pending[rs1] && !(BYPASS && wr_en && (wr_addr == rs1));
    hit2 = pending[rs2] && !(BYPASS && wr_en && (wr_addr == rs2));
    waw  = issue_wb && pending[rd] && !(wr_en && (wr_addr == rd));
    stall = issue_en && (hit1 || hit2 || waw);
    issue = issue_en && !stall;
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      set_vec[i] = issue && issue_wb && (rd == AW'(i)) && !(ZERO_REG && (i == 0));
      clr_vec[i] = wr_en && (wr_addr == AW'(i));
    end
  end

  // Pending bits: a new issue to rd outranks a writeback clearing the same register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= set_vec | (pending & ~clr_vec);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised 2R/1W register file with bypass and pending scoreboard
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int INST_W   = DEF_INST_W,
  parameter int RD_LSB   = DEF_RD_LSB,
  parameter int RS1_LSB  = DEF_RS1_LSB,
  parameter int RS2_LSB  = DEF_RS2_LSB,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic [AW-1:0]     rd;

  assign rs1 = AW'(get_field(MAX_INST_W'(bus.inst), RS1_LSB, AW));
  assign rs2 = AW'(get_field(MAX_INST_W'(bus.inst), RS2_LSB, AW));
  assign rd  = AW'(get_field(MAX_INST_W'(bus.inst), RD_LSB, AW));

  // Register storage; r0 silently drops writes when it is hardwired to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0))) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read ports: stored value, then same-cycle writeback forwarding, then the r0 override on top.
  always_comb begin
    bus.reg_data1 = regs[rs1];
    bus.reg_data2 = regs[rs2];
    if (BYPASS && bus.wr_en && (bus.wr_addr == rs1)) bus.reg_data1 = bus.wr_data;
    if (BYPASS && bus.wr_en && (bus.wr_addr == rs2)) bus.reg_data2 = bus.wr_data;
    if (ZERO_REG && (rs1 == '0)) bus.reg_data1 = '0;
    if (ZERO_REG && (rs2 == '0)) bus.reg_data2 = '0;
  end

  regfile_sb_score #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_score (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .issue_en (bus.issue_en),
    .issue_wb (bus.issue_wb),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .stall    (bus.stall),
    .pending  (bus.pending)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - table-driven scoreboard bench for regfile_sb (default and no-bypass/zero-r0 builds)
module tb_regfile_sb;

  typedef struct {
    logic [7:0] a1;
    logic [7:0] a2;
    logic       as;
    logic [7:0] ap;
    logic [7:0] b1;
    logic [7:0] b2;
    logic       bs;
    logic [7:0] bp;
  } exp_t;

  typedef struct {
    logic [15:0] inst;
    logic        ie;
    logic        iw;
    logic        we;
    logic [2:0]  wa;
    logic [7:0]  wd;
    exp_t        e;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t tbl[$];
  exp_t exp_q[$];

  regfile_sb_if #(.DATA_W(8), .NUM_REGS(8), .INST_W(16)) bus_a ();
  regfile_sb_if #(.DATA_W(8), .NUM_REGS(8), .INST_W(16)) bus_b ();

  regfile_sb u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  regfile_sb #(.ZERO_REG(1'b1), .BYPASS(1'b0)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mk(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    return {4'h0, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic vec_t v(input logic [15:0] inst, input logic ie, input logic iw,
                             input logic we, input logic [2:0] wa, input logic [7:0] wd,
                             input logic [7:0] a1, input logic [7:0] a2, input logic as, input logic [7:0] ap,
                             input logic [7:0] b1, input logic [7:0] b2, input logic bs, input logic [7:0] bp);
    vec_t r;
    r.inst = inst; r.ie = ie; r.iw = iw; r.we = we; r.wa = wa; r.wd = wd;
    r.e.a1 = a1; r.e.a2 = a2; r.e.as = as; r.e.ap = ap;
    r.e.b1 = b1; r.e.b2 = b2; r.e.bs = bs; r.e.bp = bp;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    bus_a.inst = x.inst; bus_a.issue_en = x.ie; bus_a.issue_wb = x.iw;
    bus_a.wr_en = x.we; bus_a.wr_addr = x.wa; bus_a.wr_data = x.wd;
    bus_b.inst = x.inst; bus_b.issue_en = x.ie; bus_b.issue_wb = x.iw;
    bus_b.wr_en = x.we; bus_b.wr_addr = x.wa; bus_b.wr_data = x.wd;
    exp_q.push_back(x.e);
  endtask

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_row(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s no expected entry queued", tag);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, "_a_d1"}, bus_a.reg_data1, e.a1);
    cmp({tag, "_a_d2"}, bus_a.reg_data2, e.a2);
    cmp({tag, "_a_stall"}, {7'b0, bus_a.stall}, {7'b0, e.as});
    cmp({tag, "_a_pend"}, bus_a.pending, e.ap);
    cmp({tag, "_b_d1"}, bus_b.reg_data1, e.b1);
    cmp({tag, "_b_d2"}, bus_b.reg_data2, e.b2);
    cmp({tag, "_b_stall"}, {7'b0, bus_b.stall}, {7'b0, e.bs});
    cmp({tag, "_b_pend"}, bus_b.pending, e.bp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // inst, ie, iw, we, wa, wd | A: d1, d2, stall, pend | B (no bypass, zero r0): d1, d2, stall, pend
    tbl.push_back(v(mk(0,0,0), 0,0,0,3'd0,8'h00, 8'h00,8'h00,0,8'h00, 8'h00,8'h00,0,8'h00));
    tbl.push_back(v(mk(0,1,1), 0,0,1,3'd3,8'hAA, 8'h00,8'h00,0,8'h00, 8'h00,8'h00,0,8'h00));
    tbl.push_back(v(16'hF6C0,  0,0,0,3'd0,8'h00, 8'hAA,8'h00,0,8'h00, 8'hAA,8'h00,0,8'h00));
    tbl.push_back(v(mk(0,5,3), 0,0,1,3'd5,8'h3C, 8'h3C,8'hAA,0,8'h00, 8'h00,8'hAA,0,8'h00));
    tbl.push_back(v(mk(0,5,0), 0,0,0,3'd0,8'h00, 8'h3C,8'h00,0,8'h00, 8'h3C,8'h00,0,8'h00));
    tbl.push_back(v(mk(0,0,0), 0,0,1,3'd0,8'hFF, 8'hFF,8'hFF,0,8'h00, 8'h00,8'h00,0,8'h00));
    tbl.push_back(v(mk(0,0,3), 0,0,0,3'd0,8'h00, 8'hFF,8'hAA,0,8'h00, 8'h00,8'hAA,0,8'h00));
    tbl.push_back(v(mk(2,3,5), 1,1,0,3'd0,8'h00, 8'hAA,8'h3C,0,8'h00, 8'hAA,8'h3C,0,8'h00));
    tbl.push_back(v(mk(1,0,2), 1,0,0,3'd0,8'h00, 8'hFF,8'h00,1,8'h04, 8'h00,8'h00,1,8'h04));
    tbl.push_back(v(mk(1,0,2), 1,0,1,3'd2,8'h11, 8'hFF,8'h11,0,8'h04, 8'h00,8'h00,1,8'h04));
    tbl.push_back(v(mk(0,0,2), 0,0,0,3'd0,8'h00, 8'hFF,8'h11,0,8'h00, 8'h00,8'h11,0,8'h00));
    tbl.push_back(v(mk(4,0,0), 1,1,0,3'd0,8'h00, 8'hFF,8'hFF,0,8'h00, 8'h00,8'h00,0,8'h00));
    tbl.push_back(v(mk(4,0,0), 1,1,0,3'd0,8'h00, 8'hFF,8'hFF,1,8'h10, 8'h00,8'h00,1,8'h10));
    tbl.push_back(v(mk(4,0,0), 1,1,1,3'd4,8'h44, 8'hFF,8'hFF,0,8'h10, 8'h00,8'h00,0,8'h10));
    tbl.push_back(v(mk(0,4,4), 0,0,0,3'd0,8'h00, 8'h44,8'h44,0,8'h10, 8'h44,8'h44,0,8'h10));
    tbl.push_back(v(mk(0,0,0), 1,1,0,3'd0,8'h00, 8'hFF,8'hFF,0,8'h10, 8'h00,8'h00,0,8'h10));
    tbl.push_back(v(mk(0,0,0), 0,0,0,3'd0,8'h00, 8'hFF,8'hFF,0,8'h11, 8'h00,8'h00,0,8'h10));
    tbl.push_back(v(mk(0,4,0), 0,0,1,3'd4,8'h45, 8'h45,8'hFF,0,8'h11, 8'h44,8'h00,0,8'h10));
    tbl.push_back(v(mk(0,0,0), 0,0,1,3'd0,8'h00, 8'h00,8'h00,0,8'h01, 8'h00,8'h00,0,8'h00));
    tbl.push_back(v(mk(2,1,1), 1,1,0,3'd0,8'h00, 8'h00,8'h00,0,8'h00, 8'h00,8'h00,0,8'h00));
    tbl.push_back(v(mk(3,1,1), 1,1,0,3'd0,8'h00, 8'h00,8'h00,0,8'h04, 8'h00,8'h00,0,8'h04));

    // Reset held: everything reads zero.
    rst = 1'b0;
    drive(v(mk(0,3,5), 0,0,0,3'd0,8'h00, 8'h00,8'h00,0,8'h00, 8'h00,8'h00,0,8'h00));
    @(posedge clk);
    @(negedge clk);
    check_row("in_reset");
    @(posedge clk);
    #1 rst = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      @(negedge clk);
      check_row($sformatf("row%0d", i));
    end

    // Mid-operation async reset: pending = 0C and live registers, then rst drops between edges.
    @(posedge clk);
    #1;
    drive(v(mk(0,3,5), 0,0,0,3'd0,8'h00, 8'hAA,8'h3C,0,8'h0C, 8'hAA,8'h3C,0,8'h0C));
    @(negedge clk);
    check_row("pre_async_rst");
    #2 rst = 1'b0;
    #1;
    drive(v(mk(0,3,5), 0,0,0,3'd0,8'h00, 8'h00,8'h00,0,8'h00, 8'h00,8'h00,0,8'h00));
    check_row("async_rst");
    @(posedge clk);
    #1 rst = 1'b1;

    // A late writeback after reset is an ordinary write.
    drive(v(mk(0,2,0), 0,0,1,3'd2,8'h77, 8'h77,8'h00,0,8'h00, 8'h00,8'h00,0,8'h00));
    @(negedge clk);
    check_row("late_wb");
    @(posedge clk);
    #1;
    drive(v(mk(0,2,2), 1,0,0,3'd0,8'h00, 8'h77,8'h77,0,8'h00, 8'h77,8'h77,0,8'h00));
    @(negedge clk);
    check_row("after_late_wb");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 8x8 two-read/one-write register file.
- Adds configurable width and depth, an optional hardwired-zero r0, and write-to-read bypass.
- Adds a per-register pending scoreboard so a multi-cycle writeback (load, multi-cycle ALU op) stalls dependent instructions.
- Sits between instruction decode and the ALU/writeback mux; read addresses are extracted from the instruction word.

Parameters:
DATA_W, 8, register width in bits
NUM_REGS, 8, number of registers (power of two, >=2); AW = log2(NUM_REGS) is a localparam
INST_W, 16, instruction word width
RD_LSB, 9, LSB of destination field inst[RD_LSB+AW-1:RD_LSB]
RS1_LSB, 6, LSB of source-1 field
RS2_LSB, 3, LSB of source-2 field
ZERO_REG, 0, 1 = r0 reads 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
inst  in  INST_W  current instruction; supplies rs1, rs2, rd
issue_en  in  1  instruction in decode is valid this cycle
issue_wb  in  1  instruction will write rd (marks rd pending on issue)
wr_en  in  1  writeback strobe
wr_addr  in  AW  writeback destination
wr_data  in  DATA_W  writeback data
reg_data1  out  DATA_W  value of rs1 (combinational)
reg_data2  out  DATA_W  value of rs2 (combinational)
stall  out  1  decode must hold inst; issue suppressed (combinational)
pending  out  NUM_REGS  scoreboard bits, bit i = ri awaiting writeback

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, pending = 0. Outputs follow: reg_data1/2 = 0 unless bypass is active; stall = 0.
- Write: on posedge, if rst=1 and wr_en=1 then reg[wr_addr] <= wr_data. With ZERO_REG=1, writes to r0 are dropped.
- Read: combinational. reg_dataN = reg[rsN], with these overrides:
  - BYPASS=1 and wr_en=1 and wr_addr==rsN: reg_dataN = wr_data.
  - ZERO_REG=1 and rsN==0: reg_dataN = 0. This override takes priority over bypass.
- hit1 = pending[rs1] && !(wr_en && wr_addr==rs1); hit2 is the same for rs2. With BYPASS=0, the wr_en term is removed (the data is not yet readable).
- waw = issue_wb && pending[rd] && !(wr_en && wr_addr==rd).
- stall = issue_en && (hit1 || hit2 || waw).
- issue = issue_en && !stall.
- Scoreboard update per register i, on posedge:
  - set_i = issue && issue_wb && rd==i && !(ZERO_REG && i==0).
  - clr_i = wr_en && wr_addr==i.
  - set_i wins over clr_i.
  - A clear on a non-pending register is legal and has no effect beyond the data write.
- Latency: write visible on the read ports the cycle after the edge, or the same cycle via bypass. Pending set is visible the cycle after issue.
- Reset mid-operation: pending is cleared, so any outstanding writeback that arrives later is an ordinary write.
- Unused instruction bits are ignored. Field overlap with the parameter choices is the integrator's responsibility.

Decomposition:
- Shared CPU package holds:
  - default field LSBs (RD_LSB, RS1_LSB, RS2_LSB)
  - DATA_W / NUM_REGS defaults
  - a function extracting an AW-bit field from an instruction word
- One sub-module is natural: regfile_sb_score, holding the pending vector, set/clear logic and stall generation.
- Storage, bypass and read muxing stay in the top.

Test Plan:
- Reset/write/read (defaults):
  - rst low, then high → reg_data1 = reg_data2 = 0.
  - wr_en=1, wr_addr=3, wr_data=8'hAA for one edge; inst=16'hF6C0 (rs1=3, rs2=0) → reg_data1 = 8'hAA, reg_data2 = 0.
- Bypass: wr_en=1, wr_addr=5, wr_data=8'h3C with rs1=5 in the same cycle → reg_data1 = 8'h3C before the edge.
  - Rerun with BYPASS=0 → reg_data1 keeps the old value until after the edge.
- Scoreboard RAW:
  - Issue with issue_wb=1, rd=2 → pending = 8'b0000_0100 next cycle.
  - Next inst with rs2=2 → stall = 1 and pending unchanged.
  - wr_en=1, wr_addr=2, data=8'h11 → stall = 0 that cycle, reg_data2 = 8'h11, pending = 0 after the edge.
- WAW and simultaneous set/clear:
  - r4 pending; new issue_wb to rd=4 with no writeback → stall = 1.
  - Same issue while wr_en, wr_addr=4 → no stall; pending[4] stays 1 (set wins).
- ZERO_REG=1: write 8'hFF to r0 → reads of r0 stay 0. Issue_wb to rd=0 → pending[0] stays 0 and no stall.
- Async reset mid-operation: pending = 8'h0C, registers nonzero; pull rst low between edges → pending = 0, all reads 0 immediately without waiting for a clock edge.
